// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment display controller: hex or iterative shift-add-3 decimal
// conversion, leading-zero blanking, overflow dashes and a divided digit scan.
module seg_display_scanner #(
    parameter int DIGITS   = 8,
    parameter int DATA_W   = 32,
    parameter int SCAN_DIV = 100_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
    input  logic              mode,
    input  logic              blank_lz,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        SEG,
    output logic [DIGITS-1:0] AN
);

    localparam int BCD_DIG = (DATA_W * 3) / 10 + 1;
    localparam int MAX_DIG = (DIGITS > BCD_DIG) ? DIGITS : BCD_DIG;
    localparam int EXT_W   = (DATA_W > 4 * DIGITS) ? DATA_W : 4 * DIGITS;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t               state;
    logic [DATA_W-1:0]    shift_q;
    logic [4*BCD_DIG-1:0] bcd_q;
    logic [4*BCD_DIG-1:0] bcd_adj;
    logic [CNT_W-1:0]     cnt_q;
    logic [4*DIGITS-1:0]  disp_q;
    logic [DIV_W-1:0]     div_q;
    logic [IDX_W-1:0]     idx_q;

    logic [EXT_W-1:0]     value_ext;
    logic [4*MAX_DIG-1:0] bcd_ext;
    logic [4*DIGITS-1:0]  hex_disp;
    logic [4*DIGITS-1:0]  commit_disp;
    logic                 hex_ovf;
    logic                 commit_ovf;
    logic [DIGITS-1:0]    upper_zero;
    logic                 run_zero;
    logic [3:0]           nib;
    logic [7:0]           seg_next;
    logic [DIGITS-1:0]    an_next;

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 8'hC0;
            4'h1: seg_decode = 8'hF9;
            4'h2: seg_decode = 8'hA4;
            4'h3: seg_decode = 8'hB0;
            4'h4: seg_decode = 8'h99;
            4'h5: seg_decode = 8'h92;
            4'h6: seg_decode = 8'h82;
            4'h7: seg_decode = 8'hF8;
            4'h8: seg_decode = 8'h80;
            4'h9: seg_decode = 8'h98;
            4'hA: seg_decode = 8'h88;
            4'hB: seg_decode = 8'h83;
            4'hC: seg_decode = 8'hA7;
            4'hD: seg_decode = 8'hA1;
            4'hE: seg_decode = 8'h86;
            default: seg_decode = 8'h8E;
        endcase
    endfunction

    // Widen both sources so the truncation and the out-of-range test stay legal for any DIGITS/DATA_W mix.
    always_comb begin
        value_ext   = EXT_W'(value);
        bcd_ext     = (4 * MAX_DIG)'(bcd_q);
        hex_disp    = value_ext[4*DIGITS-1:0];
        hex_ovf     = |(value_ext >> (4 * DIGITS));
        commit_disp = bcd_ext[4*DIGITS-1:0];
        commit_ovf  = |(bcd_ext >> (4 * DIGITS));
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned d = 0; d < BCD_DIG; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
    end

    // upper_zero[i]: digits i..DIGITS-1 are all zero; built top-down with a running AND.
    always_comb begin
        run_zero   = 1'b1;
        upper_zero = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            run_zero = run_zero & (disp_q[4*(DIGITS-1-k) +: 4] == 4'd0);
            upper_zero[DIGITS-1-k] = run_zero;
        end
    end

    always_comb begin
        nib     = disp_q[{idx_q, 2'b00} +: 4];
        an_next = ~(DIGITS'(1) << idx_q);
        if (overflow)
            seg_next = 8'hBF;
        else if (blank_lz && (idx_q != '0) && upper_zero[idx_q])
            seg_next = 8'hFF;
        else
            seg_next = seg_decode(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            disp_q   <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        if (mode) begin
                            disp_q   <= hex_disp;
                            overflow <= hex_ovf;
                        end else begin
                            shift_q <= value;
                            bcd_q   <= '0;
                            cnt_q   <= CNT_W'(DATA_W);
                            busy    <= 1'b1;
                            state   <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_q   <= commit_disp;
                    overflow <= commit_ovf;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
            SEG   <= 8'hFF;
            AN    <= '1;
        end else begin
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                div_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            SEG <= seg_next;
            AN  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner: a reference model pushes expected per-digit
// AN/SEG pairs to a queue, and each scan frame pops and compares them.
module tb_seg_display_scanner;

    localparam int DIGITS   = 8;
    localparam int DATA_W   = 32;
    localparam int SCAN_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load;
    logic [DATA_W-1:0] value;
    logic              mode;
    logic              blank_lz;
    logic              busy;
    logic              overflow;
    logic [7:0]        SEG;
    logic [DIGITS-1:0] AN;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .DIGITS  (DIGITS),
        .DATA_W  (DATA_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .value   (value),
        .mode    (mode),
        .blank_lz(blank_lz),
        .busy    (busy),
        .overflow(overflow),
        .SEG     (SEG),
        .AN      (AN)
    );

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t       sbq[$];
    int         checks   = 0;
    int         failures = 0;
    logic       exp_ovf;
    logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic push_frame(input logic [31:0] v, input logic hexmode, input logic blank);
        logic [3:0]  d[8];
        int unsigned r;
        logic        ovf;
        logic        nz;
        exp_t        e;
        r = v;
        if (hexmode) begin
            for (int k = 0; k < 8; k++) d[k] = v[4*k +: 4];
            ovf = 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                d[k] = 4'(r % 10);
                r    = r / 10;
            end
            ovf = (r != 0);
        end
        exp_ovf = ovf;
        for (int k = 0; k < 8; k++) begin
            nz = 1'b0;
            for (int j = k; j < 8; j++) if (d[j] != 4'd0) nz = 1'b1;
            e.an = ~(8'd1 << k);
            if (ovf)                         e.seg = 8'hBF;
            else if (blank && k > 0 && !nz)  e.seg = 8'hFF;
            else                             e.seg = seg_tab[d[k]];
            sbq.push_back(e);
        end
    endtask

    task automatic check_frame(input string tag);
        int   n;
        int   hold;
        exp_t e;
        n = 0;
        while (AN !== 8'h7F && n < 200) begin @(negedge clk); n++; end
        while (AN === 8'h7F && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_scan_sync"}, 32'(n < 200), 32'd1);
        for (int k = 0; k < 8; k++) begin
            e = sbq.pop_front();
            chk($sformatf("%s_an%0d", tag, k), 32'(AN), 32'(e.an));
            chk($sformatf("%s_seg%0d", tag, k), 32'(SEG), 32'(e.seg));
            hold = 0;
            while (AN === e.an && hold < 16) begin @(negedge clk); hold++; end
            chk($sformatf("%s_hold%0d", tag, k), 32'(hold), 32'd4);
        end
    endtask

    task automatic load_hex(input logic [31:0] v);
        load = 1'b1; value = v; mode = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hex_busy_low", 32'(busy), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic run_decimal(input logic [31:0] v, output int busy_cycles);
        load = 1'b1; value = v; mode = 1'b0;
        @(negedge clk);
        load = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        rst_n = 1'b0; load = 1'b0; value = '0; mode = 1'b0; blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seg", 32'(SEG), 32'hFF);
        chk("rst_an", 32'(AN), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load_hex(32'h1234ABCD);
        push_frame(32'h1234ABCD, 1'b1, 1'b0);
        chk("hex_ovf", 32'(overflow), 32'(exp_ovf));
        check_frame("hex");

        run_decimal(32'd12345678, bc);
        chk("dec_busy_len", 32'(bc), 32'd33);
        push_frame(32'd12345678, 1'b0, 1'b0);
        chk("dec_ovf", 32'(overflow), 32'(exp_ovf));
        check_frame("dec");

        blank_lz = 1'b1;
        run_decimal(32'd42, bc);
        chk("d42_busy_len", 32'(bc), 32'd33);
        push_frame(32'd42, 1'b0, 1'b1);
        check_frame("d42_blank");
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        push_frame(32'd42, 1'b0, 1'b0);
        check_frame("d42_noblank");

        blank_lz = 1'b1;
        run_decimal(32'd100000000, bc);
        push_frame(32'd100000000, 1'b0, 1'b1);
        chk("ovf_set", 32'(overflow), 32'(exp_ovf));
        check_frame("ovf");
        load_hex(32'd0);
        push_frame(32'd0, 1'b1, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'(exp_ovf));
        check_frame("zero");

        blank_lz = 1'b0;
        load = 1'b1; value = 32'd1000; mode = 1'b0;
        @(negedge clk);
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            bc++;
            if (bc == 5) begin load = 1'b1; value = 32'd999; mode = 1'b1; end
            else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        chk("ign_busy_len", 32'(bc), 32'd33);
        push_frame(32'd1000, 1'b0, 1'b0);
        chk("ign_ovf", 32'(overflow), 32'(exp_ovf));
        check_frame("ignored_load");

        load = 1'b1; value = 32'd99999999; mode = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(SEG), 32'hFF);
        chk("mid_rst_an", 32'(AN), 32'hFF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_an", 32'(AN), 32'hFE);
        chk("post_rst_seg", 32'(SEG), 32'hC0);
        push_frame(32'd0, 1'b1, 1'b0);
        check_frame("post_rst");
        run_decimal(32'd99999999, bc);
        chk("nines_busy_len", 32'(bc), 32'd33);
        push_frame(32'd99999999, 1'b0, 1'b0);
        chk("nines_ovf", 32'(overflow), 32'(exp_ovf));
        check_frame("nines");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
